// File: rtl/notas_pkg.sv
// Note constants shared by the tone generator and the tone detector.
// Holds the note frequencies, the index encoding and the detector FSM states.
package notas_pkg;

  localparam int NUM_NOTAS = 7;

  localparam int unsigned FREQ_DO  = 1046;
  localparam int unsigned FREQ_RE  = 1174;
  localparam int unsigned FREQ_MI  = 1318;
  localparam int unsigned FREQ_FA  = 1396;
  localparam int unsigned FREQ_SOL = 1567;
  localparam int unsigned FREQ_LA  = 1760;
  localparam int unsigned FREQ_SI  = 1975;

  typedef logic [2:0] nota_idx_t;

  localparam nota_idx_t NOTA_DO      = 3'd0;
  localparam nota_idx_t NOTA_RE      = 3'd1;
  localparam nota_idx_t NOTA_MI      = 3'd2;
  localparam nota_idx_t NOTA_FA      = 3'd3;
  localparam nota_idx_t NOTA_SOL     = 3'd4;
  localparam nota_idx_t NOTA_LA      = 3'd5;
  localparam nota_idx_t NOTA_SI      = 3'd6;
  localparam nota_idx_t NOTA_NINGUNA = 3'd7;

  typedef enum logic [1:0] {
    ESPERA,
    MIDE,
    ADQUIERE,
    FIJADO
  } estado_t;

  function automatic int unsigned nota_freq(input int idx);
    case (idx)
      0:       nota_freq = FREQ_DO;
      1:       nota_freq = FREQ_RE;
      2:       nota_freq = FREQ_MI;
      3:       nota_freq = FREQ_FA;
      4:       nota_freq = FREQ_SOL;
      5:       nota_freq = FREQ_LA;
      default: nota_freq = FREQ_SI;
    endcase
  endfunction

  // Index 7 (no note) maps to an all-zero vector rather than an out-of-range bit.
  function automatic logic [NUM_NOTAS-1:0] nota_onehot(input nota_idx_t idx);
    if (idx < nota_idx_t'(NUM_NOTAS))
      nota_onehot = NUM_NOTAS'(1) << idx;
    else
      nota_onehot = '0;
  endfunction

endpackage

// File: rtl/detector_nota_sincronizador.sv
// Brings the asynchronous tone into the clk domain and emits a one-cycle
// registered pulse on each of its rising edges.
module sincronizador_flanco (
  input  logic clk,
  input  logic reset,
  input  logic entrada,
  output logic flanco
);

  logic sync_1;
  logic sync_2;
  logic sync_3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
      flanco <= 1'b0;
    end else begin
      sync_1 <= entrada;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
      flanco <= sync_2 & ~sync_3;
    end
  end

endmodule

// File: rtl/detector_nota.sv
// Decodes a square-wave tone back into the one-hot key vector by timing the
// period between rising edges and locking after several agreeing periods.
module detector_nota
  import notas_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned CNT_W       = 17,
  parameter int unsigned MATCH_COUNT = 3,
  parameter int unsigned PERIOD_MAX  = 100000,
  parameter int unsigned TOL_SHIFT   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tono_in,
  output logic [NUM_NOTAS-1:0] notas,
  output logic                 nota_valida,
  output logic [CNT_W-1:0]     periodo
);

  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam logic [MW-1:0]    MATCH_FIN = MW'(MATCH_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PERIOD_MAX);

  logic                 flanco;
  logic [CNT_W-1:0]     cnt;
  logic [31:0]          cnt_ext;
  logic [NUM_NOTAS-1:0] en_ventana;
  nota_idx_t            clase;
  nota_idx_t            candidato;
  logic [MW-1:0]        cnt_match;
  logic [MW-1:0]        nuevo_match;
  logic                 armado;
  estado_t              estado;

  sincronizador_flanco u_sincronizador (
    .clk     (clk),
    .reset   (reset),
    .entrada (tono_in),
    .flanco  (flanco)
  );

  assign cnt_ext = 32'(cnt);

  // The counter holds the elapsed cycles since the previous edge, so on a
  // flanco cycle it already equals the period that just ended.
  for (genvar i = 0; i < NUM_NOTAS; i++) begin : g_ventana
    localparam int unsigned ESPERADO = CLK_HZ / nota_freq(i);
    localparam int unsigned MARGEN   = ESPERADO >> TOL_SHIFT;
    assign en_ventana[i] = (cnt_ext >= 32'(ESPERADO - MARGEN)) &&
                           (cnt_ext <= 32'(ESPERADO + MARGEN));
  end

  always_comb begin
    clase = NOTA_NINGUNA;
    for (int i = NUM_NOTAS - 1; i >= 0; i--) begin
      if (en_ventana[i]) clase = nota_idx_t'(i);
    end
  end

  always_comb begin
    nuevo_match = MW'(1);
    if (clase == candidato) nuevo_match = cnt_match + 1'b1;
  end

  assign nota_valida = |notas;

  // A flanco takes priority over a timeout landing in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado    <= ESPERA;
      armado    <= 1'b0;
      cnt       <= '0;
      candidato <= NOTA_NINGUNA;
      cnt_match <= '0;
      notas     <= '0;
      periodo   <= '0;
    end else if (flanco) begin
      cnt <= CNT_W'(1);
      if (armado) periodo <= cnt;
      unique case (estado)
        ESPERA: begin
          armado <= 1'b1;
          estado <= MIDE;
        end
        MIDE, ADQUIERE: begin
          if (clase == NOTA_NINGUNA) begin
            estado    <= MIDE;
            cnt_match <= '0;
          end else begin
            candidato <= clase;
            cnt_match <= nuevo_match;
            if (nuevo_match == MATCH_FIN) begin
              estado <= FIJADO;
              notas  <= nota_onehot(clase);
            end else begin
              estado <= ADQUIERE;
            end
          end
        end
        FIJADO: begin
          if (clase == NOTA_NINGUNA) begin
            notas     <= '0;
            cnt_match <= '0;
            estado    <= MIDE;
          end else if (clase != candidato) begin
            notas     <= '0;
            candidato <= clase;
            cnt_match <= MW'(1);
            estado    <= ADQUIERE;
          end
        end
        default: estado <= ESPERA;
      endcase
    end else if (cnt == CNT_MAX) begin
      notas     <= '0;
      cnt_match <= '0;
      armado    <= 1'b0;
      estado    <= ESPERA;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_detector_nota.sv
// Directed bench for detector_nota, run at a reduced clock rate so each lock
// takes only a few thousand cycles.
module tb_detector_nota;

  // At 500 kHz: DO 478 [471,485], MI 379, LA 284, SI 253, 1200 Hz -> 416.
  localparam int unsigned CLK_HZ     = 500_000;
  localparam int unsigned CNT_W      = 17;
  localparam int unsigned PERIOD_MAX = 1000;

  localparam logic [31:0] OH_DO = 32'd1;
  localparam logic [31:0] OH_MI = 32'd4;
  localparam logic [31:0] OH_LA = 32'd32;
  localparam logic [31:0] OH_SI = 32'd64;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             tono_in = 1'b0;
  logic [6:0]       notas;
  logic             nota_valida;
  logic [CNT_W-1:0] periodo;

  int check_count = 0;
  int pass_count = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int target = 0;
  logic seen;

  typedef struct {
    int   period;
    logic locks;
  } bound_t;

  bound_t bounds[4] = '{'{485, 1'b1}, '{486, 1'b0}, '{471, 1'b1}, '{470, 1'b0}};

  detector_nota #(
    .CLK_HZ      (CLK_HZ),
    .CNT_W       (CNT_W),
    .MATCH_COUNT (3),
    .PERIOD_MAX  (PERIOD_MAX),
    .TOL_SHIFT   (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tono_in     (tono_in),
    .notas       (notas),
    .nota_valida (nota_valida),
    .periodo     (periodo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected)
      pass_count++;
    else
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One tone period starting with a rising edge, driven on falling clk edges.
  task automatic applyStimulus(input int p);
    tono_in  = 1'b1;
    rise_cyc = cyc;
    wait_cycles(p / 2);
    tono_in = 1'b0;
    wait_cycles(p - p / 2);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(2);
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tono_in = ~tono_in;
      wait_cycles(3);
    end
    checkOutput("reset_notas", 32'(notas), 32'd0);
    checkOutput("reset_valida", 32'(nota_valida), 32'd0);
    checkOutput("reset_periodo", 32'(periodo), 32'd0);
    tono_in = 1'b0;
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(2);

    for (int i = 0; i < 3; i++) applyStimulus(478);
    checkOutput("do_prelock", 32'(notas), 32'd0);
    applyStimulus(478);
    checkOutput("do_lock", 32'(notas), OH_DO);
    checkOutput("do_valida", 32'(nota_valida), 32'd1);
    checkOutput("do_periodo", 32'(periodo), 32'd478);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(478);
      checkOutput("do_stable", 32'(notas), OH_DO);
    end

    // The first SI rising edge still closes a DO-length period.
    applyStimulus(253);
    checkOutput("si_edge1_do", 32'(notas), OH_DO);
    applyStimulus(253);
    checkOutput("si_switch_clear", 32'(notas), 32'd0);
    applyStimulus(253);
    checkOutput("si_acquire", 32'(notas), 32'd0);
    applyStimulus(253);
    checkOutput("si_lock", 32'(notas), OH_SI);
    checkOutput("si_periodo", 32'(periodo), 32'd253);

    foreach (bounds[k]) begin
      reset_pulse();
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        applyStimulus(bounds[k].period);
        if (i == 3)
          checkOutput($sformatf("bound_%0d_lock", bounds[k].period), 32'(notas),
                      bounds[k].locks ? OH_DO : 32'd0);
        seen = seen | nota_valida;
      end
      checkOutput($sformatf("bound_%0d_seen", bounds[k].period), 32'(seen),
                  32'(bounds[k].locks));
    end

    reset_pulse();
    for (int i = 0; i < 4; i++) applyStimulus(284);
    checkOutput("la_lock", 32'(notas), OH_LA);
    checkOutput("la_periodo", 32'(periodo), 32'd284);
    target = rise_cyc + 3 + PERIOD_MAX;
    while (cyc < target) @(negedge clk);
    checkOutput("la_before_timeout", 32'(notas), OH_LA);
    @(negedge clk);
    checkOutput("la_timeout", 32'(notas), 32'd0);
    checkOutput("la_timeout_valida", 32'(nota_valida), 32'd0);
    checkOutput("la_timeout_periodo", 32'(periodo), 32'd284);
    for (int i = 0; i < 3; i++) applyStimulus(284);
    checkOutput("la_relock_pre", 32'(notas), 32'd0);
    applyStimulus(284);
    checkOutput("la_relock", 32'(notas), OH_LA);

    reset_pulse();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(416);
      seen = seen | nota_valida;
    end
    checkOutput("offscale_seen", 32'(seen), 32'd0);
    checkOutput("offscale_periodo", 32'(periodo), 32'd416);

    reset_pulse();
    for (int i = 0; i < 4; i++) applyStimulus(379);
    checkOutput("mi_lock", 32'(notas), OH_MI);
    reset = 1'b0;
    #1;
    checkOutput("mi_async_notas", 32'(notas), 32'd0);
    checkOutput("mi_async_valida", 32'(nota_valida), 32'd0);
    checkOutput("mi_async_periodo", 32'(periodo), 32'd0);
    @(negedge clk);
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(2);
    for (int i = 0; i < 3; i++) applyStimulus(379);
    checkOutput("mi_relock_pre", 32'(notas), 32'd0);
    applyStimulus(379);
    checkOutput("mi_relock", 32'(notas), OH_MI);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
